// File: rtl/cd_sector_feeder.sv
// cd_sector_feeder: fetches one 2048-byte sector at a time from the HPS into
// a local buffer, announces it to the CDC, and streams it to sector memory.
module cd_sector_feeder #(
  parameter int SECTOR_WORDS = 1024,
  parameter int AW           = 10
) (
  input  logic          CLK_12M,
  input  logic          nRESET,
  input  logic          PLAY_START,
  input  logic          STOP,
  input  logic [7:0]    START_M,
  input  logic [7:0]    START_S,
  input  logic [7:0]    START_F,
  input  logic          NEXT_SECTOR_REQ,
  output logic          HPS_REQ,
  input  logic          HPS_WR,
  input  logic [15:0]   HPS_DIN,
  output logic [7:0]    MSF_M,
  output logic [7:0]    MSF_S,
  output logic [7:0]    MSF_F,
  output logic          SECTOR_READY,
  input  logic          DMA_START,
  input  logic          DMA_WAIT,
  output logic          DMA_WR,
  output logic [AW-1:0] DMA_ADDR,
  output logic [15:0]   DMA_DOUT,
  output logic          DMA_DONE
);

  localparam logic [AW-1:0] LAST = AW'(SECTOR_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_READY, S_GAP, S_DMA} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wcnt;
  logic          gcnt;
  logic [15:0]   mem [SECTOR_WORDS];

  // STOP outranks PLAY_START; either one cancels whatever is in flight.
  logic abort, play, acc_last;
  assign abort    = STOP | PLAY_START;
  assign play     = PLAY_START & ~STOP;
  assign acc_last = (state == S_DMA) & DMA_WR & ~DMA_WAIT & (DMA_ADDR == LAST);

  assign HPS_REQ      = (state == S_FILL);
  assign SECTOR_READY = (state == S_READY);

  // BCD digit-pair increment, low digit 9 carries into the high digit.
  function automatic logic [7:0] bcd_step(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return v + 8'd1;
  endfunction

  // State register.
  always_ff @(posedge CLK_12M or negedge nRESET) begin
    if (!nRESET) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; aborts first, then per-state transitions.
  always_comb begin
    state_nxt = state;
    if (STOP)            state_nxt = S_IDLE;
    else if (PLAY_START) state_nxt = S_FILL;
    else begin
      case (state)
        S_FILL:  if (HPS_WR && wcnt == LAST) state_nxt = S_READY;
        S_READY: if (DMA_START)              state_nxt = S_DMA;
                 else if (NEXT_SECTOR_REQ)   state_nxt = S_GAP;
        S_GAP:   if (gcnt)                   state_nxt = S_READY;
        S_DMA:   if (acc_last)               state_nxt = S_FILL;
        default: state_nxt = state;
      endcase
    end
  end

  // Fill word counter and two-cycle gap timer.
  always_ff @(posedge CLK_12M or negedge nRESET) begin
    if (!nRESET) begin
      wcnt <= '0;
      gcnt <= 1'b0;
    end else begin
      gcnt <= (state == S_GAP) ? ~gcnt : 1'b0;
      if (play || (acc_last && !abort))           wcnt <= '0;
      else if (state == S_FILL && HPS_WR && !abort) wcnt <= wcnt + AW'(1);
    end
  end

  // Sector buffer write port; HPS writes outside FILL are dropped.
  always_ff @(posedge CLK_12M) begin
    if (state == S_FILL && HPS_WR && !abort) mem[wcnt] <= HPS_DIN;
  end

  // Play position: loaded on PLAY_START, advanced with the DMA_DONE edge.
  always_ff @(posedge CLK_12M or negedge nRESET) begin
    if (!nRESET) begin
      MSF_M <= '0;
      MSF_S <= '0;
      MSF_F <= '0;
    end else if (play) begin
      MSF_M <= START_M;
      MSF_S <= START_S;
      MSF_F <= START_F;
    end else if (acc_last && !abort) begin
      if (MSF_F == 8'h74) begin
        MSF_F <= 8'h00;
        if (MSF_S == 8'h59) begin
          MSF_S <= 8'h00;
          MSF_M <= (MSF_M == 8'h99) ? 8'h00 : bcd_step(MSF_M);
        end else begin
          MSF_S <= bcd_step(MSF_S);
        end
      end else begin
        MSF_F <= bcd_step(MSF_F);
      end
    end
  end

  // DMA read side: the output registers double as the RAM read register, so
  // they simply hold while the sink applies DMA_WAIT.
  always_ff @(posedge CLK_12M or negedge nRESET) begin
    if (!nRESET) begin
      DMA_WR   <= 1'b0;
      DMA_ADDR <= '0;
      DMA_DOUT <= '0;
      DMA_DONE <= 1'b0;
    end else begin
      DMA_DONE <= 1'b0;
      if (state == S_DMA && !abort) begin
        if (!DMA_WR) begin
          DMA_WR   <= 1'b1;
          DMA_ADDR <= '0;
          DMA_DOUT <= mem[0];
        end else if (!DMA_WAIT) begin
          if (DMA_ADDR == LAST) begin
            DMA_WR   <= 1'b0;
            DMA_DONE <= 1'b1;
          end else begin
            DMA_ADDR <= DMA_ADDR + AW'(1);
            DMA_DOUT <= mem[DMA_ADDR + AW'(1)];
          end
        end
      end else begin
        DMA_WR <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cd_sector_feeder.sv
// Directed bench for cd_sector_feeder: fill, DMA (with and without
// backpressure), re-announce gap, BCD wrap, STOP/restart and async reset.
module tb_cd_sector_feeder;

  logic        CLK_12M = 1'b0;
  logic        nRESET, PLAY_START, STOP, NEXT_SECTOR_REQ, HPS_WR, DMA_START, DMA_WAIT;
  logic [7:0]  START_M, START_S, START_F;
  logic [15:0] HPS_DIN;
  logic        HPS_REQ, SECTOR_READY, DMA_WR, DMA_DONE;
  logic [7:0]  MSF_M, MSF_S, MSF_F;
  logic [9:0]  DMA_ADDR;
  logic [15:0] DMA_DOUT;

  int tests = 0;
  int fails = 0;

  cd_sector_feeder #(.SECTOR_WORDS(1024), .AW(10)) dut (
    .CLK_12M(CLK_12M), .nRESET(nRESET), .PLAY_START(PLAY_START), .STOP(STOP),
    .START_M(START_M), .START_S(START_S), .START_F(START_F),
    .NEXT_SECTOR_REQ(NEXT_SECTOR_REQ), .HPS_REQ(HPS_REQ), .HPS_WR(HPS_WR),
    .HPS_DIN(HPS_DIN), .MSF_M(MSF_M), .MSF_S(MSF_S), .MSF_F(MSF_F),
    .SECTOR_READY(SECTOR_READY), .DMA_START(DMA_START), .DMA_WAIT(DMA_WAIT),
    .DMA_WR(DMA_WR), .DMA_ADDR(DMA_ADDR), .DMA_DOUT(DMA_DOUT), .DMA_DONE(DMA_DONE)
  );

  always #5 CLK_12M = ~CLK_12M;

  task automatic step;
    @(posedge CLK_12M);
    #1;
  endtask

  task automatic test_reset;
    nRESET = 1'b0; PLAY_START = 0; STOP = 0; NEXT_SECTOR_REQ = 0; HPS_WR = 0;
    DMA_START = 0; DMA_WAIT = 0; START_M = 0; START_S = 0; START_F = 0; HPS_DIN = 0;
    repeat (2) step();
    tests++;
    if ({HPS_REQ, SECTOR_READY, DMA_WR, DMA_DONE, MSF_M, MSF_S, MSF_F, DMA_ADDR, DMA_DOUT} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got req=%b rdy=%b wr=%b done=%b msf=%h:%h:%h addr=%h dout=%h, want all 0",
               HPS_REQ, SECTOR_READY, DMA_WR, DMA_DONE, MSF_M, MSF_S, MSF_F, DMA_ADDR, DMA_DOUT);
    end
    nRESET = 1'b1;
    step();
  endtask

  // Deliver one sector of (index ^ key); optionally starts playback at m:s:f.
  task automatic test_fill(input bit play, input logic [7:0] m, s, f, input logic [15:0] key);
    int bad = 0;
    if (play) begin
      START_M = m; START_S = s; START_F = f; PLAY_START = 1'b1;
      step();
      PLAY_START = 1'b0;
      tests++;
      if (HPS_REQ !== 1'b1) begin
        fails++; $display("FAIL play_hps_req: got %b want 1", HPS_REQ);
      end
    end
    for (int i = 0; i < 1024; i++) begin
      HPS_WR = 1'b1; HPS_DIN = 16'(i) ^ key;
      step();
      if (i < 1023 && (HPS_REQ !== 1'b1 || SECTOR_READY !== 1'b0)) bad++;
    end
    HPS_WR = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL fill_levels: %0d cycles with wrong HPS_REQ/SECTOR_READY, want 0", bad);
    end
    tests++;
    if (HPS_REQ !== 1'b0 || SECTOR_READY !== 1'b1) begin
      fails++; $display("FAIL fill_ready: got req=%b rdy=%b want req=0 rdy=1", HPS_REQ, SECTOR_READY);
    end
    tests++;
    if ({MSF_M, MSF_S, MSF_F} !== {m, s, f}) begin
      fails++; $display("FAIL fill_msf: got %h:%h:%h want %h:%h:%h", MSF_M, MSF_S, MSF_F, m, s, f);
    end
  endtask

  // Stream the buffer out, optionally with random backpressure.
  task automatic test_dma(input bit rnd, input logic [15:0] key, input logic [23:0] exp_msf);
    int k = 0, cyc = 0, bad = 0;
    logic w;
    DMA_START = 1'b1;
    step();
    DMA_START = 1'b0;
    tests++;
    if (SECTOR_READY !== 1'b0 || DMA_WR !== 1'b0) begin
      fails++; $display("FAIL dma_start_lat: got rdy=%b wr=%b want 0 0", SECTOR_READY, DMA_WR);
    end
    step();
    tests++;
    if (DMA_WR !== 1'b1 || DMA_ADDR !== 10'd0) begin
      fails++; $display("FAIL dma_first: got wr=%b addr=%0d want wr=1 addr=0", DMA_WR, DMA_ADDR);
    end
    while (k < 1024 && cyc < 5000) begin
      if (DMA_WR !== 1'b1 || DMA_ADDR !== 10'(k) || DMA_DOUT !== (16'(k) ^ key) || DMA_DONE !== 1'b0) begin
        if (bad == 0)
          $display("  first bad word at k=%0d: wr=%b addr=%0d dout=%h done=%b", k, DMA_WR, DMA_ADDR, DMA_DOUT, DMA_DONE);
        bad++;
      end
      w = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
      DMA_WAIT = w;
      step();
      cyc++;
      if (!w) k++;
    end
    DMA_WAIT = 1'b0;
    tests++;
    if (bad != 0 || k != 1024) begin
      fails++; $display("FAIL dma_stream: %0d bad cycles, %0d words accepted, want 0 and 1024", bad, k);
    end
    if (!rnd) begin
      tests++;
      if (cyc != 1024) begin
        fails++; $display("FAIL dma_rate: got %0d cycles want 1024", cyc);
      end
    end
    tests++;
    if (DMA_DONE !== 1'b1 || DMA_WR !== 1'b0) begin
      fails++; $display("FAIL dma_done: got done=%b wr=%b want 1 0", DMA_DONE, DMA_WR);
    end
    tests++;
    if ({MSF_M, MSF_S, MSF_F} !== exp_msf) begin
      fails++; $display("FAIL dma_msf: got %h:%h:%h want %h", MSF_M, MSF_S, MSF_F, exp_msf);
    end
    step();
    tests++;
    if (DMA_DONE !== 1'b0 || HPS_REQ !== 1'b1) begin
      fails++; $display("FAIL dma_after: got done=%b req=%b want 0 1", DMA_DONE, HPS_REQ);
    end
  endtask

  // Re-announce gap; a stray HPS write in READY must not touch the buffer.
  task automatic test_gap(input logic [23:0] exp_msf);
    logic [2:0] seen;
    HPS_WR = 1'b1; HPS_DIN = 16'hFFFF; NEXT_SECTOR_REQ = 1'b1;
    step();
    HPS_WR = 1'b0; NEXT_SECTOR_REQ = 1'b0;
    seen[2] = SECTOR_READY;
    step();
    seen[1] = SECTOR_READY;
    step();
    seen[0] = SECTOR_READY;
    tests++;
    if (seen !== 3'b001) begin
      fails++; $display("FAIL gap_ready: got %b want 001", seen);
    end
    tests++;
    if ({MSF_M, MSF_S, MSF_F} !== exp_msf) begin
      fails++; $display("FAIL gap_msf: got %h:%h:%h want %h", MSF_M, MSF_S, MSF_F, exp_msf);
    end
  endtask

  task automatic test_stop;
    int cyc = 0, done_seen = 0;
    test_fill(1'b1, 8'h00, 8'h10, 8'h20, 16'h1234);
    DMA_START = 1'b1; step(); DMA_START = 1'b0; step();
    while (DMA_ADDR !== 10'd500 && cyc < 600) begin step(); cyc++; end
    tests++;
    if (DMA_ADDR !== 10'd500) begin
      fails++; $display("FAIL stop_reach: got addr=%0d want 500", DMA_ADDR);
    end
    STOP = 1'b1; step(); STOP = 1'b0;
    tests++;
    if (DMA_WR !== 1'b0 || HPS_REQ !== 1'b0 || SECTOR_READY !== 1'b0) begin
      fails++; $display("FAIL stop_drop: got wr=%b req=%b rdy=%b want 0 0 0", DMA_WR, HPS_REQ, SECTOR_READY);
    end
    for (int i = 0; i < 6; i++) begin
      if (DMA_DONE !== 1'b0 || DMA_WR !== 1'b0 || HPS_REQ !== 1'b0) done_seen++;
      step();
    end
    tests++;
    if (done_seen != 0) begin
      fails++; $display("FAIL stop_idle: %0d cycles with activity after STOP, want 0", done_seen);
    end
    tests++;
    if ({MSF_M, MSF_S, MSF_F} !== 24'h001020) begin
      fails++; $display("FAIL stop_msf: got %h:%h:%h want 00:10:20", MSF_M, MSF_S, MSF_F);
    end
    START_M = 8'h11; PLAY_START = 1'b1; STOP = 1'b1; step(); PLAY_START = 1'b0; STOP = 1'b0;
    tests++;
    if (HPS_REQ !== 1'b0 || MSF_M !== 8'h00) begin
      fails++; $display("FAIL stop_wins: got req=%b msf_m=%h want 0 00", HPS_REQ, MSF_M);
    end
  endtask

  // PLAY_START mid-DMA restarts; then async reset mid-FILL.
  task automatic test_restart;
    int done_seen = 0;
    test_fill(1'b1, 8'h00, 8'h02, 8'h00, 16'h0F0F);
    DMA_START = 1'b1; step(); DMA_START = 1'b0;
    repeat (5) step();
    START_M = 8'h12; START_S = 8'h34; START_F = 8'h56; PLAY_START = 1'b1;
    step();
    PLAY_START = 1'b0;
    tests++;
    if (HPS_REQ !== 1'b1 || DMA_WR !== 1'b0 || {MSF_M, MSF_S, MSF_F} !== 24'h123456) begin
      fails++; $display("FAIL restart: got req=%b wr=%b msf=%h:%h:%h want 1 0 12:34:56",
                        HPS_REQ, DMA_WR, MSF_M, MSF_S, MSF_F);
    end
    for (int i = 0; i < 4; i++) begin
      HPS_WR = 1'b1; HPS_DIN = 16'(i);
      if (DMA_DONE !== 1'b0) done_seen++;
      step();
    end
    HPS_WR = 1'b0;
    tests++;
    if (done_seen != 0) begin
      fails++; $display("FAIL restart_done: %0d DMA_DONE pulses want 0", done_seen);
    end
    nRESET = 1'b0;
    #2;
    tests++;
    if (HPS_REQ !== 1'b0 || {MSF_M, MSF_S, MSF_F} !== 24'h0 || DMA_DONE !== 1'b0) begin
      fails++; $display("FAIL async_reset: got req=%b msf=%h:%h:%h done=%b want 0 0 0",
                        HPS_REQ, MSF_M, MSF_S, MSF_F, DMA_DONE);
    end
    nRESET = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_fill(1'b1, 8'h00, 8'h02, 8'h00, 16'h0000);
    test_dma(1'b0, 16'h0000, 24'h000201);
    test_fill(1'b0, 8'h00, 8'h02, 8'h01, 16'h5A5A);
    test_gap(24'h000201);
    test_dma(1'b1, 16'h5A5A, 24'h000202);
    test_fill(1'b1, 8'h00, 8'h02, 8'h09, 16'hC3C3);
    test_dma(1'b0, 16'hC3C3, 24'h000210);
    test_fill(1'b1, 8'h00, 8'h59, 8'h74, 16'h00FF);
    test_dma(1'b0, 16'h00FF, 24'h010000);
    test_fill(1'b1, 8'h99, 8'h59, 8'h74, 16'hA5A5);
    test_dma(1'b1, 16'hA5A5, 24'h000000);
    test_stop();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cd_sector_feeder.md
# cd_sector_feeder

Upstream stage of the CD host-chip model. Holds the current play position in BCD MSF and requests one 2048-byte sector at a time from the HPS. Captures each sector into a local buffer, raises SECTOR_READY to the CDC model, and streams the buffer to the CD sector memory on DMA_START, ending with a DMA_DONE pulse. It also supplies the MSF header values that the CDC returns in its HEAD registers.

## Interface
- SECTOR_WORDS, 1024: 16-bit words per sector (2048 bytes); buffer depth.
- AW, 10: buffer and DMA address width; 2^AW must equal SECTOR_WORDS.

Ports:
- CLK_12M  in  1  sole clock; all state updates on its rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- PLAY_START  in  1  one-cycle pulse: load START_M/S/F, begin fetching.
- STOP  in  1  one-cycle pulse: abort and go idle.
- START_M, START_S, START_F  in  8 each  BCD start position.
- NEXT_SECTOR_REQ  in  1  one-cycle pulse from the CDC (STAT3 read).
- HPS_REQ  out  1  level: HPS must deliver the sector at MSF_M:S:F.
- HPS_WR  in  1  data-word strobe, one word per high cycle.
- HPS_DIN  in  16  sector data word.
- MSF_M, MSF_S, MSF_F  out  8 each  current BCD position.
- SECTOR_READY  out  1  level: buffer holds a complete sector.
- DMA_START  in  1  one-cycle pulse: begin copying the buffer out.
- DMA_WAIT  in  1  sink backpressure.
- DMA_WR  out  1  data valid toward the sector memory.
- DMA_ADDR  out  AW  word index within the sector.
- DMA_DOUT  out  16  data word.
- DMA_DONE  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States:
  - IDLE
  - FILL: HPS_REQ=1
  - READY: SECTOR_READY=1
  - GAP: SECTOR_READY forced 0 for 2 cycles
  - DMA
- IDLE -> FILL on PLAY_START: MSF loaded, word counter cleared.
- FILL:
  - Each HPS_WR writes HPS_DIN to buffer[wcnt], then wcnt increments.
  - The write at wcnt=SECTOR_WORDS-1 moves to READY on the next edge.
  - HPS_WR outside FILL is ignored.
- READY:
  - DMA_START -> DMA.
  - Otherwise NEXT_SECTOR_REQ -> GAP. GAP returns to READY after 2 cycles with buffer unchanged, so the CDC sees a fresh rising edge (re-announce for the ROM's double decoder-IRQ wait).
  - DMA_START and NEXT_SECTOR_REQ in the same cycle: DMA_START wins.
  - NEXT_SECTOR_REQ is ignored in every other state.
- DMA:
  - The buffer is read synchronously; raddr steps from 0 to SECTOR_WORDS-1.
  - A word is transferred in a cycle where DMA_WR=1 and DMA_WAIT=0.
  - While DMA_WAIT=1, DMA_WR, DMA_ADDR and DMA_DOUT hold stable.
  - On acceptance of word SECTOR_WORDS-1: DMA_DONE pulses, MSF increments, state -> FILL with wcnt=0, and HPS_REQ rises on the following cycle.
- BCD MSF increment:
  - F 0x74 -> 0x00 with carry into S; otherwise F+1 with BCD digit carry (0x09 -> 0x10).
  - S 0x59 -> 0x00 with carry into M.
  - M 0x99 -> 0x00, no flag.
  - Start values are not validated.
- STOP in any state -> IDLE: HPS_REQ, SECTOR_READY and DMA_WR drop on the next edge, no DMA_DONE, MSF retained.
- STOP together with PLAY_START: STOP wins.
- PLAY_START in any non-IDLE state restarts: MSF reloaded, any DMA in progress dropped without DMA_DONE, state -> FILL.

## Timing
- Reset values: all outputs 0, including MSF, DMA_ADDR and DMA_DOUT. State IDLE, counters 0.
- nRESET low mid-DMA or mid-FILL clears immediately, with no DMA_DONE pulse.
- PLAY_START at edge n: HPS_REQ=1 from n+1.
- Last HPS_WR at edge n: HPS_REQ=0 and SECTOR_READY=1 from n+1.
- DMA_START at edge n: SECTOR_READY=0 from n+1; first DMA_WR with DMA_ADDR=0 from n+2 (one RAM read cycle).
- No backpressure: one word per cycle, so a sector takes SECTOR_WORDS cycles. DMA_DONE is high exactly one cycle, the cycle after the final acceptance.
- MSF outputs change on the same edge that raises DMA_DONE.

## Test plan
- Reset, PLAY_START with 00:02:00, then 1024 HPS_WR words of value index -> HPS_REQ falls and SECTOR_READY rises one cycle after word 1023; MSF reads 00:02:00.
- DMA_START with DMA_WAIT=0 -> first DMA_WR 2 cycles later; 1024 consecutive words, ADDR=DOUT=0..1023; DMA_DONE pulses once; MSF becomes 00:02:01; HPS_REQ returns high.
- DMA_WAIT toggled pseudo-randomly during DMA -> outputs hold while waiting; no word lost or duplicated; DMA_DONE only after word 1023 is accepted.
- NEXT_SECTOR_REQ in READY -> SECTOR_READY low for exactly 2 cycles, then high again; buffer contents and MSF unchanged.
- Start at 00:59:74 and complete one sector, then 99:59:74 -> MSF becomes 01:00:00, then 00:00:00.
- STOP at word 500 of DMA -> DMA_WR drops next cycle, no DMA_DONE, state IDLE. PLAY_START and STOP in the same cycle -> stays IDLE.
